serial_addsub: RTL
==================

Name: serial_addsub

Overview:
- Bit-serial N-bit adder/subtractor built around one full-adder/subtractor cell plus a carry/borrow flip-flop.
- It is the clocked consumer of the combinational cell: operand bits are fed LSB-first, one per clock, and the cell's carry/borrow is registered between bits.
- A start/busy/done handshake connects it to a controller.
- Its result is the reference for checking the ripple full-adder/subtractor chain.

Parameters:
- N, 8, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request a new operation; sampled on rising clk
- a  input  N  operand A, captured when start is accepted
- b  input  N  operand B, captured when start is accepted
- a_ns  input  1  operation select, captured with operands: 1 = add (A+B), 0 = subtract (A-B)
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result, cout and ovf become valid
- result  output  N  A+B or A-B, mod 2^N
- cout  output  1  add: carry out of MSB; subtract: borrow out (1 iff A < B unsigned)
- ovf  output  1  two's-complement signed overflow of the operation

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; internal shift registers, bit counter and carry flop cleared.
- States:
  - IDLE: wait for start.
  - RUN: process one bit per cycle.
  - DONE: one cycle, done=1.
- IDLE + start=1 at edge k:
  - load sh_a=a, sh_b=b, op=a_ns, carry=0, cnt=0.
  - next state RUN; busy=1 from edge k.
- RUN, each edge:
  - Cell inputs: sh_a[0], sh_b[0], carry, op.
  - Add cell: s = a^b^cin; co = ab | cin(a^b).
  - Subtract cell: s = a^b^cin; co = (~a)b | cin(~(a^b)).
  - On the edge: sh_a and sh_b shift right; s shifts into the result shift register at the MSB; carry <= co; cnt++.
  - When cnt reaches N-1, that edge processes the last bit. The same edge goes to DONE and computes ovf.
- Overflow rule:
  - add: ovf = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]).
  - subtract: ovf = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]).
  - a and b here are the captured operands.
- Latency and output timing:
  - start accepted at edge k; last bit processed at edge k+N; done=1 during the cycle after edge k+N.
  - busy is high from edge k to edge k+N, and 0 in DONE.
  - result, cout and ovf update only at the DONE entry edge. They are held stable until the next DONE entry or reset; they never show partial values.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 in the DONE cycle is accepted (back-to-back): load and go to RUN. Otherwise go to IDLE.
- start while in RUN is ignored: no reload, no effect on the running operation.
- Operand or a_ns changes after acceptance have no effect.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs cleared. The first start after reset release is handled normally.
- Width rules:
  - cnt is $clog2(N) bits.
  - The final cell co is the cout value directly; no extra inversion for subtract.

Decomposition:
- Package serial_addsub_pkg holds:
  - state enum: ST_IDLE, ST_RUN, ST_DONE.
  - constants: OP_ADD = 1'b1, OP_SUB = 1'b0.
- One natural sub-module: the existing single-bit fas cell (ports a, b, cin, a_ns, s, cout), instantiated once for the serial datapath.
- Sequencing, shift registers and overflow logic stay in serial_addsub.

Test Plan (N=8):
- add 100 + 55, a_ns=1, start one cycle -> done exactly 9 edges after start edge; result=155, cout=0, ovf=1 (signed 100+55 > 127).
- add 200 + 100 -> result=44, cout=1, ovf=0; busy high for 8 cycles, done pulse 1 cycle.
- subtract 5 - 7, a_ns=0 -> result=254, cout=1 (borrow), ovf=0; then 7 - 5 -> result=2, cout=0.
- subtract 128 - 1 (-128 - 1 signed) -> result=127, cout=0, ovf=1. Then:
  - start held high through RUN -> ignored.
  - start in DONE cycle -> second operation accepted back-to-back with correct result.
- Reset mid-RUN: start 3 + 4, assert rst after 3 edges -> outputs 0 immediately, no done. Then start 3 + 4 -> result=7.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/serial_addsub_if.sv
// Controller-facing handshake and operand/result bundle for serial_addsub.
interface serial_addsub_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         a_ns;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a, b, a_ns,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, a, b, a_ns,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_fas.sv
// Single-bit full adder/subtractor cell; cout is carry (add) or borrow (subtract).
module fas
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a_ns == OP_ADD) ? ((a & b) | (cin & (a ^ b)))
                                   : ((~a & b) | (cin & ~(a ^ b)));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: one fas cell, LSB-first, carry/borrow registered per bit.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_addsub_if.slave   bus
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   sh_a_q, sh_b_q;
    logic [N-2:0]   sh_r_q;
    logic [CW-1:0]  cnt_q;
    logic           op_q, carry_q;
    logic           a_msb_q, b_msb_q;
    logic [N-1:0]   result_q;
    logic           cout_q, ovf_q;

    logic           cell_s, cell_co;
    logic           load, last_bit, ovf_d;
    logic [N-1:0]   r_full;

    fas u_fas (
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .cin  (carry_q),
        .a_ns (op_q),
        .s    (cell_s),
        .cout (cell_co)
    );

    // Start is honoured in IDLE and, for back-to-back operation, in DONE.
    assign load     = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST);
    assign r_full   = {cell_s, sh_r_q};
    assign ovf_d    = ((op_q == OP_ADD) ? (a_msb_q == b_msb_q) : (a_msb_q != b_msb_q))
                      && (cell_s != a_msb_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_r_q   <= '0;
            cnt_q    <= '0;
            op_q     <= OP_SUB;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (load) begin
            sh_a_q   <= bus.a;
            sh_b_q   <= bus.b;
            op_q     <= bus.a_ns;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= bus.a[N-1];
            b_msb_q  <= bus.b[N-1];
        end else if (state_q == ST_RUN) begin
            sh_a_q  <= sh_a_q >> 1;
            sh_b_q  <= sh_b_q >> 1;
            sh_r_q  <= r_full[N-1:1];
            carry_q <= cell_co;
            cnt_q   <= cnt_q + 1'b1;
            // Visible outputs change only here, so partial sums never leak out.
            if (last_bit) begin
                result_q <= r_full;
                cout_q   <= cell_co;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule
